// File: rtl/stack_seq.sv
// Stack push/pop sequencer for the $29 stack pointer.
// Drives register-file, ALU and memory control for one push or pop at a time.
// The memory handshake waits at most TIMEOUT cycles and then reports an error.
// All outputs are registered and decoded from the state being entered.
module stack_seq #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       op,
  input  logic [4:0] rt,
  input  logic       mem_ready,
  output logic [1:0] regdst_sel,
  output logic       reg_write,
  output logic       wb_sel,
  output logic [1:0] alu_sel,
  output logic       mem_read,
  output logic       mem_write,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH_SP,
    S_PUSH_MEM,
    S_POP_MEM,
    S_POP_WB,
    S_POP_SP,
    S_DONE,
    S_ERR
  } state_t;

  // Last allowed wait count: the TIMEOUT-th memory cycle without mem_ready errors out.
  localparam logic [3:0] LP_LAST_WAIT = 4'(TIMEOUT - 1);

  // Output vector: {regdst_sel, reg_write, wb_sel, alu_sel, mem_read, mem_write, busy, done, err}
  function automatic logic [10:0] f_outputs(input state_t s);
    logic [10:0] v;
    v = '0;
    case (s)
      S_IDLE:     v = 11'b00_0_0_00_0_0_0_0_0;
      S_PUSH_SP:  v = 11'b10_1_0_01_0_0_1_0_0;
      S_PUSH_MEM: v = 11'b00_0_0_00_0_1_1_0_0;
      S_POP_MEM:  v = 11'b00_0_0_00_1_0_1_0_0;
      S_POP_WB:   v = 11'b00_1_1_00_0_0_1_0_0;
      S_POP_SP:   v = 11'b10_1_0_10_0_0_1_0_0;
      S_DONE:     v = 11'b00_0_0_00_0_0_1_1_0;
      S_ERR:      v = 11'b00_0_0_00_0_0_1_0_1;
      default:    v = '0;
    endcase
    return v;
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_op;
  logic [4:0]  r_rt;
  logic [10:0] r_out;

  // Next-state selection; a pop into $29 skips the stack-pointer increment.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = op ? S_POP_MEM : S_PUSH_SP;
      S_PUSH_SP:  w_next = S_PUSH_MEM;
      S_PUSH_MEM,
      S_POP_MEM: begin
        if (mem_ready)                 w_next = r_op ? S_POP_WB : S_DONE;
        else if (r_cnt == LP_LAST_WAIT) w_next = S_ERR;
      end
      S_POP_WB:   w_next = (r_rt == 5'd29) ? S_DONE : S_POP_SP;
      S_POP_SP:   w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      S_ERR:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // State, wait counter, latched instruction fields and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= 1'b0;
      r_rt    <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_next;
      r_out   <= f_outputs(w_next);
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_state == S_PUSH_MEM || r_state == S_POP_MEM)
        r_cnt <= r_cnt + 4'd1;
      if (r_state == S_IDLE && start) begin
        r_op <= op;
        r_rt <= rt;
      end
    end
  end

  assign {regdst_sel, reg_write, wb_sel, alu_sel, mem_read, mem_write, busy, done, err} = r_out;

endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq: directed table, mid-operation reset, and randomized
// transactions checked cycle by cycle against an expected control trace.
module tb_stack_seq;
  localparam int T = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       op;
  logic [4:0] rt;
  logic       mem_ready;
  logic [1:0] regdst_sel;
  logic       reg_write;
  logic       wb_sel;
  logic [1:0] alu_sel;
  logic       mem_read;
  logic       mem_write;
  logic       busy;
  logic       done;
  logic       err;

  stack_seq #(.TIMEOUT(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .rt         (rt),
    .mem_ready  (mem_ready),
    .regdst_sel (regdst_sel),
    .reg_write  (reg_write),
    .wb_sel     (wb_sel),
    .alu_sel    (alu_sel),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected per-cycle output vectors for the transaction in flight.
  logic [10:0] exp_q[$];

  int   obs_busy;
  logic obs_done;
  logic obs_err;

  typedef struct {
    logic       op;
    logic [4:0] rt;
    int         d;
    int         busy_cyc;
    logic       done_exp;
    logic       err_exp;
  } row_t;

  row_t tbl[8];

  // {regdst, reg_write, wb_sel, alu, mem_read, mem_write, busy, done, err}
  function automatic logic [10:0] vec(input logic [1:0] rd, input logic rw, input logic wb,
                                      input logic [1:0] alu, input logic mr, input logic mw,
                                      input logic dn, input logic er);
    return {rd, rw, wb, alu, mr, mw, 1'b1, dn, er};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {regdst_sel, reg_write, wb_sel, alu_sel, mem_read, mem_write, busy, done, err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference trace: d = number of waits before mem_ready (d >= T means never in time).
  task automatic build(input logic o, input logic [4:0] r, input int d);
    int n_mem;
    exp_q.delete();
    n_mem = (d < T) ? d + 1 : T;
    if (!o) exp_q.push_back(vec(2'b10, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < n_mem; i++)
      exp_q.push_back(vec(2'b00, 1'b0, 1'b0, 2'b00, o, !o, 1'b0, 1'b0));
    if (d >= T) begin
      exp_q.push_back(vec(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    end else begin
      if (o) begin
        exp_q.push_back(vec(2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        if (r != 5'd29)
          exp_q.push_back(vec(2'b10, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      exp_q.push_back(vec(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
    end
  endtask

  // Issue one operation from IDLE and compare every cycle against the trace.
  // With noisy set, start/op/rt toggle while busy and mem_ready toggles outside memory cycles.
  task automatic run_txn(input logic o, input logic [4:0] r, input int d, input logic noisy);
    int w;
    build(o, r, d);
    obs_busy = 0;
    obs_done = 1'b0;
    obs_err  = 1'b0;
    w = 0;
    start = 1'b1;
    op = o;
    rt = r;
    mem_ready = noisy ? 1'($urandom % 2) : 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      check($sformatf("trace_op%0d_rt%0d_d%0d_c%0d", o, r, d, k), dut_vec(), exp_q[k]);
      if (busy) obs_busy++;
      if (done) obs_done = 1'b1;
      if (err)  obs_err  = 1'b1;
      if (exp_q[k][4] | exp_q[k][3]) begin
        mem_ready = (w == d);
        w++;
      end else begin
        mem_ready = noisy ? 1'($urandom % 2) : 1'b0;
      end
      start = noisy ? 1'($urandom % 2) : 1'b0;
      if (noisy) begin
        op = 1'($urandom % 2);
        rt = 5'($urandom % 32);
      end
      tick();
    end
    start = 1'b0;
    mem_ready = 1'b0;
    check("idle_after", dut_vec(), 32'd0);
  endtask

  initial begin
    tbl[0] = '{1'b0, 5'd8,  0,  3,  1'b1, 1'b0};
    tbl[1] = '{1'b1, 5'd9,  2,  6,  1'b1, 1'b0};
    tbl[2] = '{1'b1, 5'd29, 0,  3,  1'b1, 1'b0};
    tbl[3] = '{1'b0, 5'd8,  99, 17, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 5'd4,  14, 17, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 5'd7,  15, 16, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 5'd29, 14, 17, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 5'd31, 5,  8,  1'b1, 1'b0};

    reset = 1'b0;
    start = 1'b0;
    op = 1'b0;
    rt = 5'd0;
    mem_ready = 1'b0;
    #2;
    check("reset_state", dut_vec(), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("idle_after_reset", dut_vec(), 32'd0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].op, tbl[i].rt, tbl[i].d, 1'b0);
      check($sformatf("busy_cycles_row%0d", i), 32'(obs_busy), 32'(tbl[i].busy_cyc));
      check($sformatf("done_row%0d", i), 32'(obs_done), 32'(tbl[i].done_exp));
      check($sformatf("err_row%0d", i), 32'(obs_err), 32'(tbl[i].err_exp));
    end

    // Start pulses held high during a pop's memory wait are ignored
    run_txn(1'b1, 5'd12, 4, 1'b1);
    check("one_done_with_start_noise", 32'(obs_done), 32'd1);

    // Asynchronous reset during PUSH_MEM, then a normal pop
    start = 1'b1;
    op = 1'b0;
    rt = 5'd3;
    tick();
    start = 1'b0;
    tick();
    check("push_mem_before_reset", 32'(mem_write), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_clears", dut_vec(), 32'd0);
    tick();
    mem_ready = 1'b1;
    tick();
    check("held_in_reset", dut_vec(), 32'd0);
    mem_ready = 1'b0;
    reset = 1'b1;
    tick();
    check("idle_after_release", dut_vec(), 32'd0);
    run_txn(1'b1, 5'd10, 1, 1'b0);
    check("pop_after_reset_done", 32'(obs_done), 32'd1);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      logic       ro;
      logic [4:0] rr;
      int         rd;
      ro = 1'($urandom % 2);
      rr = ($urandom % 4 == 0) ? 5'd29 : 5'($urandom % 32);
      rd = int'($urandom_range(0, 17));
      run_txn(ro, rr, rd, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stack_seq.md
STACK_SEQ -- requirements
Module: stack_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max cycles to wait for mem_ready per memory access (1..15).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to run a push/pop, sampled in IDLE only.
REQ-005 SHALL have port op  input  1  0 = push (mem[$29-4] <= rt, $29 -= 4), 1 = pop (rt <= mem[$29], $29 += 4).
REQ-006 SHALL have port rt  input  5  register field of the instruction, latched with start.
REQ-007 SHALL have port mem_ready  input  1  memory completion strobe.
REQ-008 SHALL have port regdst_sel  output  2  write-register mux select: 00 rt, 01 rd, 10 $29, 11 $31.
REQ-009 SHALL have port reg_write  output  1  register-file write enable.
REQ-010 SHALL have port wb_sel  output  1  write-data select: 0 ALU result, 1 memory data.
REQ-011 SHALL have port alu_sel  output  2  00 pass $29, 01 $29-4, 10 $29+4, 11 unused.
REQ-012 SHALL have port mem_read / mem_write  output  1 each  memory strobes, address = ALU result.
REQ-013 SHALL have ports busy, done, err  output  1 each  status.

Function
REQ-014 SHALL implement FSM states IDLE, PUSH_SP, PUSH_MEM, POP_MEM, POP_WB, POP_SP, DONE, ERR.
REQ-015 IDLE: busy=0, all strobes 0; on start=1 latch op and rt; next state PUSH_SP if op=0, else POP_MEM.
REQ-016 PUSH_SP (1 cycle): alu_sel=01, wb_sel=0, regdst_sel=10, reg_write=1; next PUSH_MEM.
REQ-017 PUSH_MEM: alu_sel=00 (updated $29), mem_write=1 held until mem_ready=1; on mem_ready next DONE.
REQ-018 POP_MEM: alu_sel=00, mem_read=1 held until mem_ready=1; on mem_ready next POP_WB.
REQ-019 POP_WB (1 cycle): wb_sel=1, regdst_sel=00, reg_write=1; next POP_SP, except latched rt=29 -> next DONE (loaded value wins, $29 not incremented).
REQ-020 POP_SP (1 cycle): alu_sel=10, wb_sel=0, regdst_sel=10, reg_write=1; next DONE.
REQ-021 DONE: done=1 for exactly one cycle; next IDLE.
REQ-022 busy=1 in every state except IDLE; start while busy SHALL be ignored (not queued).
REQ-023 SHALL count wait cycles in PUSH_MEM/POP_MEM with 4-bit counter cleared on state entry; if counter reaches TIMEOUT with mem_ready still 0, next ERR, strobes deasserted.
REQ-024 mem_ready=1 on the same cycle the counter reaches TIMEOUT SHALL count as success, not timeout.
REQ-025 ERR: err=1 for one cycle, no writes; next IDLE. Push timeout leaves $29 already decremented (software-visible, documented).
REQ-026 mem_ready asserted while not in a memory state SHALL be ignored.
REQ-027 reg_write SHALL be asserted at most once per cycle and only in PUSH_SP, POP_WB, POP_SP.
REQ-028 Push latency with mem_ready on first cycle: start to done = 3 cycles (PUSH_SP, PUSH_MEM, DONE); pop = 4 cycles (3 if rt=29).

Reset
REQ-029 reset=0 SHALL asynchronously force IDLE, counter 0, latched op/rt 0, regdst_sel=00, reg_write=0, wb_sel=0, alu_sel=00, mem_read=0, mem_write=0, busy=0, done=0, err=0.
REQ-030 Reset mid-operation SHALL abort immediately with no further strobes; release resumes in IDLE on next rising edge.

Verification
REQ-031 Push, rt=8, mem_ready on first PUSH_MEM cycle -> cycle1 reg_write regdst=10 alu=01; cycle2 mem_write alu=00; cycle3 done=1; busy 3 cycles.
REQ-032 Pop, rt=9, mem_ready after 2 waits -> mem_read 3 cycles, then reg_write regdst=00 wb=1, then reg_write regdst=10 alu=10, then done.
REQ-033 Pop, rt=29 -> POP_WB write to rt only, no POP_SP cycle, done one cycle after POP_WB.
REQ-034 Push, mem_ready never asserted, TIMEOUT=15 -> mem_write for 15 cycles, err=1 one cycle, done never asserted, IDLE after.
REQ-035 start pulsed during POP_MEM -> ignored; exactly one done pulse for the operation.
REQ-036 reset=0 asserted during PUSH_MEM -> all outputs 0 asynchronously; after release a new pop completes normally.
